// File: rtl/spi_slave_bridge_pkg.sv
// Shared types and constants for the SPI slave bridge (mode 3, MSB first).
// Optional statistics counters are enabled with SPI_SLAVE_BRIDGE_STATS_EN.
package spi_slave_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  localparam int                  SPI_BYTE_W       = 8;
  localparam logic [SPI_BYTE_W-1:0] TX_IDLE_BYTE_DEF = 8'hFF;
  localparam bit                  CPOL             = 1'b1;
  localparam bit                  CPHA             = 1'b1;

endpackage

// File: rtl/spi_slave_bridge_if.sv
// Byte-stream handshake between the SPI slave bridge and its register/command logic.
interface spi_slave_bridge_if;
  import spi_slave_pkg::*;

  logic [SPI_BYTE_W-1:0] rx_data_o;
  logic                  rx_valid_o;
  logic                  rx_ready_i;
  logic [SPI_BYTE_W-1:0] tx_data_i;
  logic                  tx_valid_i;
  logic                  tx_ready_o;

  modport slave (
    output rx_data_o, rx_valid_o, tx_ready_o,
    input  rx_ready_i, tx_data_i, tx_valid_i
  );

  modport master (
    input  rx_data_o, rx_valid_o, tx_ready_o,
    output rx_ready_i, tx_data_i, tx_valid_i
  );

endinterface

// File: rtl/spi_slave_bridge_fifo.sv
// Synchronous RX FIFO; when full, a same-cycle pop frees the slot for the push.
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  // Head reads as zero while empty so the output is defined without resetting storage.
  assign data_o  = empty_o ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/spi_slave_bridge.sv
// SPI mode-3 slave: oversampled pins, RX FIFO and TX holding register on sys_clk.
// Define SPI_SLAVE_BRIDGE_STATS_EN to add frame_cnt_o / byte_cnt_o counters.
module spi_slave_bridge
  import spi_slave_pkg::*;
#(
  parameter int                    SYNC_STAGES  = 2,
  parameter int                    RX_DEPTH     = 4,
  parameter logic [SPI_BYTE_W-1:0] TX_IDLE_BYTE = TX_IDLE_BYTE_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic spi_clk_i,
  input  logic spi_cs_i,
  input  logic spi_mosi_i,
  output logic spi_miso_o,
  spi_slave_bridge_if.slave bus,
  output logic rx_overflow_o,
  output logic tx_underrun_o,
  input  logic clr_i
`ifdef SPI_SLAVE_BRIDGE_STATS_EN
  ,
  output logic [15:0] frame_cnt_o,
  output logic [15:0] byte_cnt_o
`endif
);

  logic [SYNC_STAGES-1:0] cs_p0, sclk_p0, mosi_p0;
  logic                   cs_p1, sclk_p1;
  logic                   cs_s, sclk_s, mosi_s;
  logic                   cs_fall, cs_rise, sclk_fall, sclk_rise;
  spi_state_t             state_q, state_d;
  logic                   start, stop, sh_fall, sh_rise, byte_done, reload;
  logic [2:0]             bit_cnt;
  logic [SPI_BYTE_W-1:0]  rx_shreg, tx_shreg, tx_hold, push_data_p1;
  logic                   tx_full, tx_load, idle_pend, push_vld_p1;
  logic                   fifo_full, fifo_empty, rx_pop;

  // Stage p0: pin synchronisers; p1: one extra copy for edge detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cs_p0   <= '1;
      sclk_p0 <= '1;
      mosi_p0 <= '0;
      cs_p1   <= 1'b1;
      sclk_p1 <= 1'b1;
    end else begin
      cs_p0   <= {cs_p0[SYNC_STAGES-2:0], spi_cs_i};
      sclk_p0 <= {sclk_p0[SYNC_STAGES-2:0], spi_clk_i};
      mosi_p0 <= {mosi_p0[SYNC_STAGES-2:0], spi_mosi_i};
      cs_p1   <= cs_s;
      sclk_p1 <= sclk_s;
    end
  end

  assign cs_s      = cs_p0[SYNC_STAGES-1];
  assign sclk_s    = sclk_p0[SYNC_STAGES-1];
  assign mosi_s    = mosi_p0[SYNC_STAGES-1];
  assign cs_fall   = cs_p1 & ~cs_s;
  assign cs_rise   = ~cs_p1 & cs_s;
  assign sclk_fall = sclk_p1 & ~sclk_s;
  assign sclk_rise = ~sclk_p1 & sclk_s;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // A CS edge masks any SCLK edge seen in the same cycle.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    stop    = 1'b0;
    sh_fall = 1'b0;
    sh_rise = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          start   = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          stop    = 1'b1;
        end else if (!cs_fall) begin
          sh_fall = sclk_fall;
          sh_rise = sclk_rise;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_done = sh_rise & (bit_cnt == 3'd7);
  assign reload    = start | byte_done;
  assign tx_load   = bus.tx_valid_i & ~tx_full;
  assign rx_pop    = bus.rx_valid_o & bus.rx_ready_i;

  // Stage p1: completed byte registered once more before entering the FIFO
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_cnt       <= '0;
      rx_shreg      <= '0;
      tx_shreg      <= TX_IDLE_BYTE;
      tx_hold       <= '0;
      tx_full       <= 1'b0;
      idle_pend     <= 1'b0;
      spi_miso_o    <= 1'b1;
      push_vld_p1   <= 1'b0;
      push_data_p1  <= '0;
      rx_overflow_o <= 1'b0;
      tx_underrun_o <= 1'b0;
    end else begin
      push_vld_p1 <= byte_done;
      if (byte_done) push_data_p1 <= {rx_shreg[SPI_BYTE_W-2:0], mosi_s};

      if (start) begin
        bit_cnt <= '0;
      end else if (sh_rise) begin
        rx_shreg <= {rx_shreg[SPI_BYTE_W-2:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
      end

      // Underrun is flagged only once the idle byte actually starts leaving on MISO.
      if (reload) begin
        tx_shreg  <= tx_full ? tx_hold : TX_IDLE_BYTE;
        idle_pend <= ~tx_full;
      end else if (sh_fall) begin
        spi_miso_o <= tx_shreg[SPI_BYTE_W-1];
        tx_shreg   <= {tx_shreg[SPI_BYTE_W-2:0], 1'b0};
        idle_pend  <= 1'b0;
      end else if (stop) begin
        spi_miso_o <= 1'b1;
      end

      if (reload && tx_full) tx_full <= 1'b0;
      else if (tx_load)      tx_full <= 1'b1;
      if (tx_load) tx_hold <= bus.tx_data_i;

      if (sh_fall && idle_pend) tx_underrun_o <= 1'b1;
      else if (clr_i)           tx_underrun_o <= 1'b0;
      if (push_vld_p1 && fifo_full && !rx_pop) rx_overflow_o <= 1'b1;
      else if (clr_i)                          rx_overflow_o <= 1'b0;
    end
  end

  spi_sync_fifo #(
    .WIDTH (SPI_BYTE_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push_i    (push_vld_p1),
    .data_i    (push_data_p1),
    .pop_i     (rx_pop),
    .data_o    (bus.rx_data_o),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign bus.rx_valid_o = ~fifo_empty;
  assign bus.tx_ready_o = ~tx_full;

`ifdef SPI_SLAVE_BRIDGE_STATS_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_cnt_o <= '0;
      byte_cnt_o  <= '0;
    end else if (clr_i) begin
      frame_cnt_o <= '0;
      byte_cnt_o  <= '0;
    end else begin
      if (stop)      frame_cnt_o <= frame_cnt_o + 16'd1;
      if (byte_done) byte_cnt_o  <= byte_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_bridge.sv
// Scoreboard bench for spi_slave_bridge: directed SPI frames, RX queue checked by a monitor.
module tb_spi_slave_bridge;
  import spi_slave_pkg::*;

  localparam int SS  = 2;
  localparam int H   = 6;
  localparam int LAT = SS + 2;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic spi_clk = 1'b1;
  logic spi_cs = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso;
  logic rx_overflow, tx_underrun;
  logic clr = 1'b0;

  spi_slave_bridge_if bus();

  spi_slave_bridge #(
    .SYNC_STAGES  (SS),
    .RX_DEPTH     (4),
    .TX_IDLE_BYTE (8'hFF)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .spi_clk_i     (spi_clk),
    .spi_cs_i      (spi_cs),
    .spi_mosi_i    (spi_mosi),
    .spi_miso_o    (spi_miso),
    .bus           (bus),
    .rx_overflow_o (rx_overflow),
    .tx_underrun_o (tx_underrun),
    .clr_i         (clr)
  );

  always #5 sys_clk = ~sys_clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rise_cyc = 0;
  int rise_cnt = 0;
  bit chk_lat  = 1'b0;
  logic vld_prev = 1'b0;
  logic [7:0] rx_exp[$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected queue whenever the consumer handshake completes.
  initial forever begin
    @(negedge sys_clk);
    if (sys_rst_n) begin
      if (chk_lat && bus.rx_valid_o && !vld_prev)
        check("rx_latency", 32'(cyc - rise_cyc), 32'(LAT));
      if (bus.rx_valid_o && bus.rx_ready_i) begin
        if (rx_exp.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL rx_unexpected: got %0h expected none", bus.rx_data_o);
        end else begin
          check("rx_data", 32'(bus.rx_data_o), 32'(rx_exp.pop_front()));
        end
      end
    end
    vld_prev = bus.rx_valid_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge sys_clk);
      spi_clk  = 1'b0;
      spi_mosi = tx[7-i];
      repeat (H) @(negedge sys_clk);
      rx       = {rx[6:0], spi_miso};
      spi_clk  = 1'b1;
      rise_cyc = cyc;
      rise_cnt++;
      repeat (H-1) @(negedge sys_clk);
    end
  endtask

  task automatic cs_low();
    @(negedge sys_clk);
    spi_cs = 1'b0;
    repeat (H) @(negedge sys_clk);
  endtask

  task automatic cs_high();
    repeat (H) @(negedge sys_clk);
    spi_cs = 1'b1;
    repeat (2*H) @(negedge sys_clk);
  endtask

  task automatic tx_preload(input logic [7:0] b);
    @(negedge sys_clk);
    bus.tx_data_i  = b;
    bus.tx_valid_i = 1'b1;
    @(negedge sys_clk);
    bus.tx_valid_i = 1'b0;
  endtask

  task automatic set_ready(input logic v);
    @(posedge sys_clk);
    #2 bus.rx_ready_i = v;
  endtask

  task automatic clr_pulse();
    @(negedge sys_clk);
    clr = 1'b1;
    @(negedge sys_clk);
    clr = 1'b0;
    @(negedge sys_clk);
  endtask

  logic [7:0] rd;
  int tgt;

  initial begin
    bus.rx_ready_i = 1'b0;
    bus.tx_valid_i = 1'b0;
    bus.tx_data_i  = '0;
    repeat (3) @(negedge sys_clk);
    check("rst_miso", 32'(spi_miso), 32'd1);
    check("rst_rx_valid", 32'(bus.rx_valid_o), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data_o), 32'd0);
    check("rst_tx_ready", 32'(bus.tx_ready_o), 32'd1);
    check("rst_overflow", 32'(rx_overflow), 32'd0);
    check("rst_underrun", 32'(tx_underrun), 32'd0);
    sys_rst_n = 1'b1;

    // Single frame with preloaded TX byte
    set_ready(1'b1);
    tx_preload(8'h3C);
    check("tx_ready_loaded", 32'(bus.tx_ready_o), 32'd0);
    rx_exp.push_back(8'hA5);
    chk_lat = 1'b1;
    cs_low();
    spi_xfer(8'hA5, 8, rd);
    cs_high();
    chk_lat = 1'b0;
    check("miso_3c", 32'(rd), 32'h3C);
    check("tx_ready_freed", 32'(bus.tx_ready_o), 32'd1);
    check("single_underrun", 32'(tx_underrun), 32'd0);
    check("single_overflow", 32'(rx_overflow), 32'd0);
    check("single_drained", 32'(rx_exp.size()), 32'd0);

    // Underrun: three bytes with nothing to send
    cs_low();
    for (int k = 0; k < 3; k++) begin
      rx_exp.push_back(8'(8'h11 * (k + 1)));
      spi_xfer(8'(8'h11 * (k + 1)), 8, rd);
      check("miso_idle", 32'(rd), 32'hFF);
    end
    cs_high();
    check("underrun_set", 32'(tx_underrun), 32'd1);
    clr_pulse();
    check("underrun_clr", 32'(tx_underrun), 32'd0);

    // Overflow: five bytes into a four-deep FIFO with no consumer
    set_ready(1'b0);
    cs_low();
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) rx_exp.push_back(8'(k));
      spi_xfer(8'(k), 8, rd);
    end
    cs_high();
    check("overflow_set", 32'(rx_overflow), 32'd1);
    check("overflow_valid", 32'(bus.rx_valid_o), 32'd1);
    set_ready(1'b1);
    repeat (10) @(negedge sys_clk);
    check("overflow_drained", 32'(rx_exp.size()), 32'd0);
    check("overflow_empty", 32'(bus.rx_valid_o), 32'd0);
    clr_pulse();
    check("overflow_clr", 32'(rx_overflow), 32'd0);

    // Abort after five bits, then a clean byte
    tx_preload(8'h00);
    cs_low();
    spi_xfer(8'hF0, 5, rd);
    check("abort_miso_mid", 32'(spi_miso), 32'd0);
    cs_high();
    check("abort_miso_idle", 32'(spi_miso), 32'd1);
    check("abort_no_push", 32'(bus.rx_valid_o), 32'd0);
    rx_exp.push_back(8'h55);
    cs_low();
    spi_xfer(8'h55, 8, rd);
    cs_high();
    check("abort_next_byte", 32'(rx_exp.size()), 32'd0);

    // Reset in the middle of a frame
    cs_low();
    spi_xfer(8'h96, 3, rd);
    tx_preload(8'hAB);
    check("pre_rst_underrun", 32'(tx_underrun), 32'd1);
    check("pre_rst_tx_ready", 32'(bus.tx_ready_o), 32'd0);
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("mid_rst_miso", 32'(spi_miso), 32'd1);
    check("mid_rst_rx_valid", 32'(bus.rx_valid_o), 32'd0);
    check("mid_rst_rx_data", 32'(bus.rx_data_o), 32'd0);
    check("mid_rst_tx_ready", 32'(bus.tx_ready_o), 32'd1);
    check("mid_rst_underrun", 32'(tx_underrun), 32'd0);
    check("mid_rst_overflow", 32'(rx_overflow), 32'd0);
    spi_cs  = 1'b1;
    spi_clk = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    rx_exp.push_back(8'hC3);
    cs_low();
    spi_xfer(8'hC3, 8, rd);
    cs_high();
    check("post_rst_byte", 32'(rx_exp.size()), 32'd0);

    // Full FIFO with a pop in the very cycle the fifth byte is pushed
    set_ready(1'b0);
    cs_low();
    for (int k = 1; k <= 4; k++) begin
      rx_exp.push_back(8'(8'hA0 + k));
      spi_xfer(8'(8'hA0 + k), 8, rd);
    end
    rx_exp.push_back(8'hA5);
    tgt = rise_cnt + 8;
    fork
      spi_xfer(8'hA5, 8, rd);
      begin
        wait (rise_cnt == tgt);
        repeat (3) @(posedge sys_clk);
        #2 bus.rx_ready_i = 1'b1;
        @(posedge sys_clk);
        #2 bus.rx_ready_i = 1'b0;
      end
    join
    cs_high();
    check("simul_no_overflow", 32'(rx_overflow), 32'd0);
    check("simul_held", 32'(rx_exp.size()), 32'd4);
    set_ready(1'b1);
    repeat (10) @(negedge sys_clk);
    check("simul_drained", 32'(rx_exp.size()), 32'd0);
    check("simul_empty", 32'(bus.rx_valid_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_bridge.md
Name: spi_slave_bridge

Overview:
Synthesizable SPI slave that terminates the SPI bus driven by the DPI-backed SPI master model (spi_cs / spi_sclk / spi_mosi in, spi_miso out). Oversamples the SPI pins on sys_clk, deserialises MOSI bytes into an RX FIFO with a valid/ready interface, and serialises TX bytes from a valid/ready holding register onto MISO. Sits directly downstream of the master model and feeds the on-chip register/command logic.

Parameters:
SYNC_STAGES, 2, synchroniser depth for spi_cs_i, spi_clk_i and spi_mosi_i (legal values 2..4)
RX_DEPTH, 4, RX FIFO depth in bytes (power of 2, ≥2)
TX_IDLE_BYTE, 8'hFF, byte shifted out when no TX data is available

Ports:
sys_clk  input  1  system clock; all logic on its rising edge
sys_rst_n  input  1  asynchronous active-low reset
spi_clk_i  input  1  SPI SCLK from master, idles high (CPOL=1)
spi_cs_i  input  1  SPI chip select, active low
spi_mosi_i  input  1  master-out data
spi_miso_o  output  1  slave-out data
rx_data_o  output  8  head of RX FIFO
rx_valid_o  output  1  RX FIFO non-empty
rx_ready_i  input  1  consumer pops on rx_valid_o & rx_ready_i
tx_data_i  input  8  next byte to transmit
tx_valid_i  input  1  TX byte offered
tx_ready_o  output  1  TX holding register empty
rx_overflow_o  output  1  sticky: RX byte dropped because FIFO full
tx_underrun_o  output  1  sticky: TX_IDLE_BYTE sent because holding register empty
clr_i  input  1  synchronous clear of both sticky flags

Behaviour:
- Reset (async, sys_rst_n=0): spi_miso_o=1, rx_valid_o=0, rx_data_o=0, tx_ready_o=1, both flags 0, FIFO empty, state IDLE, synchroniser flops preset to cs=1, sclk=1, mosi=0. Reset mid-frame abandons the frame completely.
- Pins pass through SYNC_STAGES flops. Edge detection compares the last synced sample against one extra registered copy. Requirement: SCLK high and low phases each ≥ SYNC_STAGES+1 sys_clk cycles.
- SPI mode 3 (CPOL=1, CPHA=1), MSB first: MISO updates on SCLK falling edge; MOSI is sampled on SCLK rising edge.
- FSM IDLE -> ACTIVE on synced CS falling edge:
  - bit_cnt=0.
  - tx_shreg loaded from the holding register if full (which frees it, tx_ready_o=1 next cycle); otherwise loaded with TX_IDLE_BYTE and tx_underrun_o set.
- ACTIVE, falling SCLK: spi_miso_o <= tx_shreg[7], tx_shreg <<= 1.
- ACTIVE, rising SCLK: rx_shreg <= {rx_shreg[6:0], mosi}, bit_cnt++ (3-bit, wraps).
  - On the 8th rising edge (bit_cnt 7->0), the assembled byte is pushed to the RX FIFO.
  - On the same edge, tx_shreg reloads under the same rule as frame start.
- ACTIVE -> IDLE on synced CS rising edge:
  - A partial byte (bit_cnt≠0) is discarded silently.
  - spi_miso_o returns to 1.
  - A pending TX byte stays in the holding register.
- Latency: rx_valid_o rises SYNC_STAGES+2 sys_clk cycles after the 8th SCLK rising edge at the pin.
- RX FIFO full on push: the byte is dropped and rx_overflow_o set. If a pop occurs in the same cycle, the pop wins the slot and the push is accepted without overflow.
- TX holding register loads on tx_valid_i & tx_ready_o. A load in the same cycle as a frame/byte-boundary reload does not feed that reload; it is used at the next boundary.
- clr_i clears the flags. If clr_i coincides with a set event, the set wins.
- CS edge and SCLK edge detected in the same cycle: CS takes priority and the SCLK edge is ignored.

Optional Feature:
SPI_SLAVE_BRIDGE_STATS_EN:
- Defined: adds outputs frame_cnt_o[15:0] (increments on each CS rising edge) and byte_cnt_o[15:0] (increments on each complete RX byte). Both reset to 0, wrap at 16'hFFFF->0, and clear on clr_i.
- Undefined: these ports and their counters do not exist.

Decomposition:
- Package spi_slave_pkg holds:
  - state enum spi_state_t {IDLE, ACTIVE}
  - SPI_BYTE_W=8
  - default TX_IDLE_BYTE
  - mode constants CPOL=1, CPHA=1
- Sub-module spi_sync_fifo implements the RX FIFO: parameterised width/depth, push/pop/full/empty, pop-priority-when-full.

Test Plan:
- Single frame: master sends 8'hA5 in one CS frame while 8'h3C is preloaded on TX -> rx_data_o=8'hA5 with rx_valid_o 4 cycles after the 8th rising edge (SYNC_STAGES=2), master reads 8'h3C, no flags set.
- Underrun: 3-byte frame with TX empty -> master reads 8'hFF,8'hFF,8'hFF, tx_underrun_o=1; clr_i pulse -> flag 0.
- Overflow: rx_ready_i=0, 5 bytes 8'h01..8'h05 sent -> FIFO holds 01..04, rx_overflow_o=1; draining yields 01,02,03,04 only.
- Abort: CS deasserted after 5 bits of 8'hF0 -> no RX push, spi_miso_o=1, next full byte 8'h55 received correctly.
- Reset mid-frame: sys_rst_n low after 3 bits -> all outputs at reset values immediately; a new frame after release receives 8'hC3 correctly.
- Full-FIFO simultaneous push/pop: FIFO full with rx_ready_i=1 in the push cycle -> byte accepted, rx_overflow_o stays 0.
